// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter:
// FSM state encoding, default oversampling ratio, parity-type constants
// and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_PARITY_EVEN = 0;
  localparam int UART_PARITY_ODD  = 1;

  // Expected parity bit for a word (upper unused bits must be zero).
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL so the output is well defined out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, oversampled by baud_tick, LSB first.
// Optional parity check is enabled by defining UART_RX_PARITY_EN; without it
// the frame is start + DATA_BITS + stop and parity_err is tied low.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | line idle, waiting for synchronized rx low
// ST_START     | counting to the centre of the start bit, rejects glitches
// ST_DATA      | sampling DATA_BITS data bits at bit centres
// ST_PARITY    | sampling the parity bit (only with UART_RX_PARITY_EN)
// ST_STOP      | sampling the stop bit, reporting the frame
// ST_WAIT_IDLE | bad stop bit seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = UART_PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  // Reject parameter sets the datapath widths are not sized for.
  if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
    $error("uart_rx: unsupported DATA_BITS/OVERSAMPLE/PARITY_ODD");
  end

  uart_state_e          state_q, state_d;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 tick_half, tick_full;
  logic                 cnt_clr, cnt_inc;
  logic                 shift_en, par_en, stop_ok, stop_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick_half = baud_tick && (cnt_q == CNT_HALF);
  assign tick_full = baud_tick && (cnt_q == CNT_FULL);
  assign busy      = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (tick_half) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else if (baud_tick) begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_full) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else if (baud_tick) begin
          cnt_inc = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_full) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_d = ST_STOP;
        end else if (baud_tick) begin
          cnt_inc = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick_full) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end
        end else if (baud_tick) begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Oversampling tick counter and data-bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (state_q != ST_DATA) bit_q <= '0;
      else if (shift_en)      bit_q <= bit_q + 1'b1;
    end
  end

  // Shift register, output word and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      if (shift_en) shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
      if (stop_ok)  rx_data <= shreg_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  // Captured parity bit and the parity check reported with rx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_q <= rx_s;
      parity_err <= stop_ok && (parity_of(8'(shreg_q), 1'(PARITY_ODD)) != par_q);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (8 data bits, 16x oversampling, even parity
// when UART_RX_PARITY_EN is defined).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int OS         = 16;
  localparam bit PARITY_ODD = 1'b0;

  logic       clk, rst_n, baud_tick, rx;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    bit         valid;
    bit         ferr;
    bit         perr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         pflip;
    bit         stop;
    bit         exp_valid;
    bit         exp_ferr;
    bit         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] model_last = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud_tick: one clock in four, updated just after the rising edge.
  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Record every output pulse seen by the DUT.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (rx_valid || frame_err || parity_err))
        ev_q.push_back('{valid: rx_valid, ferr: frame_err, perr: parity_err, data: rx_data});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    int got;
    got = 0;
    while (got < n) begin
      @(negedge clk);
      if (baud_tick) got++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop, input int stop_ticks);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    wait_ticks(OS);
`endif
    rx = stop;
    wait_ticks(stop_ticks);
  endtask

  function automatic bit even_par_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Reference: what one frame should produce, from the frame contents alone.
  function automatic ev_t model_event(input logic [7:0] d, input bit pbit, input bit stop);
    ev_t e;
    e.valid = stop;
    e.ferr  = !stop;
    e.perr  = stop && PAR_EN && (pbit != (even_par_bit(d) ^ PARITY_ODD));
    e.data  = stop ? d : model_last;
    return e;
  endfunction

  task automatic check_events(input string name);
    int n;
    chk({name, ".count"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, ".valid"}, ev_q[i].valid, exp_q[i].valid);
      chk({name, ".frame_err"}, ev_q[i].ferr, exp_q[i].ferr);
      chk({name, ".parity_err"}, ev_q[i].perr, exp_q[i].perr);
      chk({name, ".data"}, ev_q[i].data, exp_q[i].data);
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[8];
    ev_t  e;
    tbl[0] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55};
    tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
    tbl[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
    tbl[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81};
    tbl[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset.rx_data", rx_data, 8'h00);
    chk("reset.rx_valid", rx_valid, 1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    chk("reset.parity_err", parity_err, 1'b0);
    chk("reset.busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_ticks(4);
    chk("idle.busy", busy, 1'b0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, even_par_bit(tbl[i].data) ^ PARITY_ODD ^ tbl[i].pflip, tbl[i].stop, OS);
      if (!tbl[i].stop) begin
        rx = 1'b1;
        wait_ticks(OS);
      end else begin
        wait_ticks(4);
      end
      exp_q.push_back('{valid: tbl[i].exp_valid, ferr: tbl[i].exp_ferr,
                        perr: PAR_EN && tbl[i].exp_perr, data: tbl[i].exp_data});
      check_events($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.hold", i), rx_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d.busy", i), busy, 1'b0);
    end
    model_last = 8'h80;

    // Short low glitch on an idle line is a false start.
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(1);
    chk("glitch.busy_hi", busy, 1'b1);
    wait_ticks(10);
    chk("glitch.busy_lo", busy, 1'b0);
    check_events("glitch");

    // Bad stop bit with the line held low for three bit periods.
    send_frame(8'hA5, even_par_bit(8'hA5), 1'b0, 3 * OS);
    chk("brk.busy_held", busy, 1'b1);
    exp_q.push_back(model_event(8'hA5, even_par_bit(8'hA5), 1'b0));
    check_events("brk");
    rx = 1'b1;
    wait_ticks(2);
    chk("brk.busy_lo", busy, 1'b0);
    chk("brk.hold", rx_data, model_last);

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, even_par_bit(8'hA5), 1'b1, OS);
    exp_q.push_back(model_event(8'hA5, even_par_bit(8'hA5), 1'b1));
    model_last = 8'hA5;
    send_frame(8'h3C, even_par_bit(8'h3C), 1'b1, OS);
    exp_q.push_back(model_event(8'h3C, even_par_bit(8'h3C), 1'b1));
    model_last = 8'h3C;
    wait_ticks(2);
    check_events("b2b");

    // Reset during data bit 4, then a clean frame.
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_ticks(OS);
    end
    rx = 1'b0;
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.rx_data", rx_data, 8'h00);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    model_last = 8'h00;
    wait_ticks(2 * OS);
    check_events("midrst.aborted");
    send_frame(8'h81, even_par_bit(8'h81), 1'b1, OS);
    exp_q.push_back(model_event(8'h81, even_par_bit(8'h81), 1'b1));
    model_last = 8'h81;
    wait_ticks(2);
    check_events("midrst.clean");

`ifdef UART_RX_PARITY_EN
    // 0x03 has even weight: parity bit 1 is wrong, 0 is right.
    send_frame(8'h03, 1'b1, 1'b1, OS);
    exp_q.push_back('{valid: 1'b1, ferr: 1'b0, perr: 1'b1, data: 8'h03});
    check_events("par.bad");
    send_frame(8'h03, 1'b0, 1'b1, OS);
    exp_q.push_back('{valid: 1'b1, ferr: 1'b0, perr: 1'b0, data: 8'h03});
    check_events("par.good");
    model_last = 8'h03;
`endif

    // Randomized frames against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit         pb, st;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 4) != 0);
      gap = st ? $urandom_range(0, 20) : $urandom_range(4, 20);
      send_frame(d, pb, st, OS);
      e = model_event(d, pb, st);
      exp_q.push_back(e);
      if (st) model_last = d;
      check_events($sformatf("rnd%0d", i));
      if (gap > 0) begin
        rx = 1'b1;
        wait_ticks(gap);
        chk($sformatf("rnd%0d.hold", i), rx_data, model_last);
      end
    end
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("end.busy", busy, 1'b0);
    check_events("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
